// File: rtl/riscv_pushpop_sequencer.sv
// -----------------------------------------------------------------------------
// riscv_pushpop_sequencer
//
// Multi-cycle sequencer for the compressed stack instructions PUSH, POP,
// POPRET and POPRETZ. It sits beside the ID-stage decoder. After a start it
// walks the encoded register list and issues one LSU access per register,
// highest-numbered register first and x1 last. Every offset is relative to
// the sp value seen at start. It then applies the sp adjustment, zeroes a0
// for POPRETZ, and requests a return jump for POPRET/POPRETZ.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           decoded push/pop valid (sampled only while idle)
//   op_i              00 PUSH, 01 POP, 10 POPRET, 11 POPRETZ
//   rlist_i           register-list encoding (values below 4 are illegal)
//   spimm_i           extra stack space in STACK_ALIGN units
//   flush_i           synchronous abort of a running sequence
//   lsu_req_o/gnt_i   LSU access handshake
//   lsu_we_o          1 = store (PUSH), 0 = load
//   lsu_reg_o         architectural register being stored or loaded
//   lsu_off_o         signed byte offset from the original sp
//   sp_we_o/sp_adj_o  sp write strobe and signed value added to sp
//   a0_zero_we_o      write x10 = 0
//   ret_o             jump-to-ra request
//   busy_o            sequence in progress
//   done_o            last-cycle pulse
//   illegal_o         illegal rlist pulse
// -----------------------------------------------------------------------------
module riscv_pushpop_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STACK_ALIGN = 16,
  parameter int unsigned SPIMM_W     = 2,
  parameter int unsigned OFF_W       = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [3:0]         rlist_i,
  input  logic [SPIMM_W-1:0] spimm_i,
  input  logic               flush_i,
  output logic               lsu_req_o,
  input  logic               lsu_gnt_i,
  output logic               lsu_we_o,
  output logic [4:0]         lsu_reg_o,
  output logic [OFF_W-1:0]   lsu_off_o,
  output logic               sp_we_o,
  output logic [OFF_W-1:0]   sp_adj_o,
  output logic               a0_zero_we_o,
  output logic               ret_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               illegal_o
);

  localparam int unsigned SB = XLEN / 8;
  // One extra bit so that negation and ADJ - k*SB cannot overflow.
  localparam int unsigned AW = OFF_W + 1;
  localparam int unsigned MAX_ADJ =
      ((13 * SB + STACK_ALIGN - 1) / STACK_ALIGN) * STACK_ALIGN +
      ((1 << SPIMM_W) - 1) * STACK_ALIGN;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POPRET  = 2'b10;
  localparam logic [1:0] OP_POPRETZ = 2'b11;

  generate
    if (MAX_ADJ > (1 << (OFF_W - 1)) - 1) begin : g_adj_range_err
      $error("riscv_pushpop_sequencer: maximum stack adjustment does not fit in OFF_W");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_err
      $error("riscv_pushpop_sequencer: XLEN must be 32 or 64");
    end
    if ((STACK_ALIGN & (STACK_ALIGN - 1)) != 0 || STACK_ALIGN == 0) begin : g_align_err
      $error("riscv_pushpop_sequencer: STACK_ALIGN must be a power of two");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XFER = 3'd1,
    S_ADJ  = 3'd2,
    S_ZERO = 3'd3,
    S_RET  = 3'd4
  } state_e;

  // Number of registers named by a (legal) rlist encoding.
  function automatic logic [3:0] reg_count(input logic [3:0] rlist);
    logic [3:0] n;
    if (rlist == 4'd15) begin
      n = 4'd13;   // rlist 15 skips x26 alone and covers x18..x27
    end else begin
      n = rlist - 4'd3;
    end
    return n;
  endfunction

  // Register at ascending list position idx: x1, x8, x9, x18, x19, ...
  function automatic logic [4:0] reg_at(input logic [3:0] idx);
    logic [4:0] r;
    case (idx)
      4'd0:    r = 5'd1;
      4'd1:    r = 5'd8;
      4'd2:    r = 5'd9;
      default: r = 5'd15 + {1'b0, idx};
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [3:0]         rlist_q, rlist_d;
  logic [SPIMM_W-1:0] spimm_q, spimm_d;
  logic [3:0]         k_q, k_d;

  logic [3:0]    n_s;
  logic [3:0]    idx_s;
  logic [AW-1:0] slots_s;
  logic [AW-1:0] round_s;
  logic [AW-1:0] adj_s;
  logic [AW-1:0] koff_s;
  logic [AW-1:0] off_s;
  logic [AW-1:0] sp_adj_s;
  logic          unused_s;

  // Access k = 1 is the highest-numbered register, so it is list position N-k.
  assign n_s      = reg_count(rlist_q);
  assign idx_s    = n_s - k_q;
  assign slots_s  = AW'(n_s) * AW'(SB);
  assign round_s  = (slots_s + AW'(STACK_ALIGN - 1)) & ~AW'(STACK_ALIGN - 1);
  assign adj_s    = round_s + AW'(spimm_q) * AW'(STACK_ALIGN);
  assign koff_s   = AW'(k_q) * AW'(SB);
  assign off_s    = (op_q == OP_PUSH) ? (-koff_s) : (adj_s - koff_s);
  assign sp_adj_s = (op_q == OP_PUSH) ? (-adj_s) : adj_s;
  // The guard bit only protects the intermediate arithmetic.
  assign unused_s = off_s[OFF_W] ^ sp_adj_s[OFF_W];

  // State and latched instruction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      rlist_q <= 4'd0;
      spimm_q <= '0;
      k_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rlist_q <= rlist_d;
      spimm_q <= spimm_d;
      k_q     <= k_d;
    end
  end

  // Next-state and output decode. A flush masks every strobe in the same cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rlist_d      = rlist_q;
    spimm_d      = spimm_q;
    k_d          = k_q;
    lsu_req_o    = 1'b0;
    lsu_we_o     = 1'b0;
    lsu_reg_o    = 5'd0;
    lsu_off_o    = '0;
    sp_we_o      = 1'b0;
    sp_adj_o     = '0;
    a0_zero_we_o = 1'b0;
    ret_o        = 1'b0;
    done_o       = 1'b0;
    illegal_o    = 1'b0;
    busy_o       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (rlist_i < 4'd4) begin
            illegal_o = 1'b1;
          end else begin
            op_d    = op_i;
            rlist_d = rlist_i;
            spimm_d = spimm_i;
            k_d     = 4'd1;
            state_d = S_XFER;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_XFER: begin
        // Request fields depend only on registered state, so they stay
        // stable for as long as the grant is withheld.
        lsu_we_o  = (op_q == OP_PUSH);
        lsu_reg_o = reg_at(idx_s);
        lsu_off_o = off_s[OFF_W-1:0];
        if (flush_i) begin
          k_d     = 4'd0;
          state_d = S_IDLE;
        end else begin
          lsu_req_o = 1'b1;
          if (lsu_gnt_i) begin
            if (k_q == n_s) begin
              k_d     = 4'd0;
              state_d = S_ADJ;
            end else begin
              k_d = k_q + 4'd1;
            end
          end else begin
            k_d = k_q;
          end
        end
      end

      S_ADJ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          sp_we_o  = 1'b1;
          sp_adj_o = sp_adj_s[OFF_W-1:0];
          if (op_q == OP_POPRETZ) begin
            state_d = S_ZERO;
          end else if (op_q == OP_POPRET) begin
            state_d = S_RET;
          end else begin
            done_o  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_ZERO: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          a0_zero_we_o = 1'b1;
          state_d      = S_RET;
        end
      end

      S_RET: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          ret_o   = 1'b1;
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        k_d     = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
